// File: rtl/distribute_1x2_simple_seq_pkg.sv
// ============================================================================
//  Module   : distribute_1x2_simple_seq_pkg
//  Brief    : Shared NoC constants: routing commands and buffer state type.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package distribute_1x2_simple_seq_pkg;

  localparam int COMMAND_WIDTH_DEFAULT = 2;

  localparam logic [1:0] CMD_DROP  = 2'b00;
  localparam logic [1:0] CMD_LOW   = 2'b01;
  localparam logic [1:0] CMD_HIGH  = 2'b10;
  localparam logic [1:0] CMD_BCAST = 2'b11;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slice_state_t;

endpackage : distribute_1x2_simple_seq_pkg

`default_nettype wire

// File: rtl/distribute_1x2_simple_seq_reg_slice_1entry.sv
// ============================================================================
//  Module   : reg_slice_1entry
//  Brief    : One-entry valid/ready output buffer with pass-through on drain.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_slice_1entry
  import distribute_1x2_simple_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_can_accept,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  slice_state_t          r_state;
  slice_state_t          w_state_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_wr;

  assign o_can_accept = (r_state == ST_EMPTY) || i_ready;
  // A write into a stalled full entry would overwrite an undelivered flit.
  assign w_wr         = i_wr && o_can_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_wr) w_state_next = ST_FULL;
      ST_FULL:  if (i_ready && !w_wr) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_wr) begin
      r_data <= i_data;
    end
  end

  assign o_valid = (r_state == ST_FULL);
  assign o_data  = o_valid ? r_data : {DATA_WIDTH{1'b0}};

endmodule : reg_slice_1entry

`default_nettype wire

// File: rtl/distribute_1x2_simple_seq.sv
// ============================================================================
//  Module   : distribute_1x2_simple_seq
//  Brief    : Registered 1-to-2 flit distributor (drop/low/high/broadcast).
//             Broadcast is built only when DISTRIBUTE_1X2_BCAST_EN is defined;
//             otherwise command 2'b11 acts as drop.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module distribute_1x2_simple_seq
  import distribute_1x2_simple_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = COMMAND_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data_bus,
  output logic                    o_ready,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus,
  input  logic [1:0]              i_ready,
  input  logic                    i_en,
  input  logic [COMMAND_WIDTH-1:0] i_cmd
);

  logic [1:0] w_target;
  logic [1:0] w_can_accept;
  logic [1:0] w_wr;
  logic       w_transfer;

`ifdef DISTRIBUTE_1X2_BCAST_EN
  assign w_target[0] = (i_cmd == COMMAND_WIDTH'(CMD_LOW))  || (i_cmd == COMMAND_WIDTH'(CMD_BCAST));
  assign w_target[1] = (i_cmd == COMMAND_WIDTH'(CMD_HIGH)) || (i_cmd == COMMAND_WIDTH'(CMD_BCAST));
`else
  assign w_target[0] = (i_cmd == COMMAND_WIDTH'(CMD_LOW));
  assign w_target[1] = (i_cmd == COMMAND_WIDTH'(CMD_HIGH));
`endif

  // Every targeted branch must accept, which keeps broadcast all-or-nothing.
  assign o_ready    = i_en && !rst
                    && (!w_target[0] || w_can_accept[0])
                    && (!w_target[1] || w_can_accept[1]);
  assign w_transfer = i_valid && o_ready;
  assign w_wr       = w_target & {2{w_transfer}};

  for (genvar b = 0; b < 2; b++) begin : g_branch
    reg_slice_1entry #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slice (
      .clk          (clk),
      .rst          (rst),
      .i_wr         (w_wr[b]),
      .i_data       (i_data_bus),
      .i_ready      (i_ready[b]),
      .o_can_accept (w_can_accept[b]),
      .o_valid      (o_valid[b]),
      .o_data       (o_data_bus[b*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule : distribute_1x2_simple_seq

`default_nettype wire

// File: tb/tb_distribute_1x2_simple_seq.sv
// ============================================================================
//  Module   : tb_distribute_1x2_simple_seq
//  Brief    : Directed self-checking bench for distribute_1x2_simple_seq.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_distribute_1x2_simple_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data_bus = '0;
  logic          o_ready;
  logic [1:0]    o_valid;
  logic [2*DW-1:0] o_data_bus;
  logic [1:0]    i_ready = 2'b00;
  logic          i_en = 1'b0;
  logic [1:0]    i_cmd = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;

  distribute_1x2_simple_seq #(.DATA_WIDTH(DW), .COMMAND_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready),
    .i_en       (i_en),
    .i_cmd      (i_cmd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; i_en = 1'b1; i_ready = 2'b11;
    #1;
    n_checks++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b exp 00", o_valid); end
    n_checks++; if (o_data_bus !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", o_data_bus); end
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", o_ready); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_low();
    i_cmd = 2'b01; i_data_bus = 32'hA5A5_0001; i_valid = 1'b1; i_ready = 2'b11;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL low_ready got %b exp 1", o_ready); end
    step();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o_valid !== 2'b01) begin n_fail++; $display("FAIL low_valid got %b exp 01", o_valid); end
    n_checks++; if (o_data_bus !== {32'h0, 32'hA5A5_0001}) begin n_fail++; $display("FAIL low_data got %h exp 00000000a5a50001", o_data_bus); end
    step();
    n_checks++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL low_drain got %b exp 00", o_valid); end
  endtask

  task automatic test_back_to_back();
    i_cmd = 2'b01; i_ready = 2'b11; i_valid = 1'b1; i_data_bus = 32'h1111_0001;
    step();
    i_data_bus = 32'h1111_0002;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", o_ready); end
    n_checks++; if (o_data_bus[31:0] !== 32'h1111_0001) begin n_fail++; $display("FAIL b2b_first got %h exp 11110001", o_data_bus[31:0]); end
    step();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o_valid !== 2'b01 || o_data_bus[31:0] !== 32'h1111_0002) begin
      n_fail++; $display("FAIL b2b_second got v=%b d=%h exp v=01 d=11110002", o_valid, o_data_bus[31:0]);
    end
    step();
  endtask

  task automatic test_stream_high();
    logic [DW-1:0] flits [4];
    logic [DW-1:0] rx [4];
    int idx = 0;
    int got = 0;
    logic acc;
    flits[0] = 32'hC0DE_0000; flits[1] = 32'hC0DE_0011;
    flits[2] = 32'hC0DE_0022; flits[3] = 32'hC0DE_0033;
    i_cmd = 2'b10;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      i_ready    = (cyc == 1 || cyc == 2) ? 2'b01 : 2'b11;
      i_valid    = (idx < 4);
      i_data_bus = (idx < 4) ? flits[idx] : '0;
      #1;
      if (cyc == 1 || cyc == 2) begin
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stream_stall_ready cyc %0d got %b exp 0", cyc, o_ready); end
        n_checks++; if (o_valid[1] !== 1'b1 || o_data_bus[63:32] !== flits[0]) begin
          n_fail++; $display("FAIL stream_stall_hold cyc %0d got v=%b d=%h exp v=1 d=%h", cyc, o_valid[1], o_data_bus[63:32], flits[0]);
        end
      end
      if (o_valid[1] && i_ready[1]) begin
        rx[got] = o_data_bus[63:32];
        got++;
      end
      acc = i_valid && o_ready;
      step();
      if (acc) idx++;
    end
    i_valid = 1'b0;
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL stream_count got %0d exp 4", got); end
    for (int k = 0; k < got; k++) begin
      n_checks++; if (rx[k] !== flits[k]) begin n_fail++; $display("FAIL stream_order idx %0d got %h exp %h", k, rx[k], flits[k]); end
    end
    n_checks++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL stream_empty got %b exp 00", o_valid); end
  endtask

  task automatic test_bcast();
    i_cmd = 2'b01; i_data_bus = 32'hBEEF_0001; i_valid = 1'b1; i_ready = 2'b00;
    step();
    i_cmd = 2'b11; i_data_bus = 32'h1234_5678; i_ready = 2'b10;
    #1;
`ifdef DISTRIBUTE_1X2_BCAST_EN
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_block_ready got %b exp 0", o_ready); end
    step();
    #1;
    n_checks++; if (o_valid !== 2'b01 || o_data_bus !== {32'h0, 32'hBEEF_0001}) begin
      n_fail++; $display("FAIL bcast_no_partial got v=%b d=%h exp v=01 d=00000000beef0001", o_valid, o_data_bus);
    end
    i_ready = 2'b11;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_go_ready got %b exp 1", o_ready); end
    step();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o_valid !== 2'b11 || o_data_bus !== {32'h1234_5678, 32'h1234_5678}) begin
      n_fail++; $display("FAIL bcast_both got v=%b d=%h exp v=11 d=1234567812345678", o_valid, o_data_bus);
    end
`else
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_drop_ready got %b exp 1", o_ready); end
    step();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o_valid !== 2'b01 || o_data_bus !== {32'h0, 32'hBEEF_0001}) begin
      n_fail++; $display("FAIL bcast_drop_state got v=%b d=%h exp v=01 d=00000000beef0001", o_valid, o_data_bus);
    end
`endif
    i_ready = 2'b11;
    step();
    n_checks++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL bcast_drain got %b exp 00", o_valid); end
  endtask

  task automatic test_drop();
    i_cmd = 2'b00; i_data_bus = 32'hDEAD_0000; i_valid = 1'b1; i_ready = 2'b11;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready got %b exp 1", o_ready); end
    step();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL drop_valid got %b exp 00", o_valid); end
  endtask

  task automatic test_en_low();
    i_cmd = 2'b01; i_data_bus = 32'h0E0E_0001; i_valid = 1'b1; i_ready = 2'b00;
    step();
    i_en = 1'b0; i_data_bus = 32'h0E0E_0002; i_ready = 2'b01;
    #1;
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_ready got %b exp 0", o_ready); end
    n_checks++; if (o_valid !== 2'b01) begin n_fail++; $display("FAIL en_low_held got %b exp 01", o_valid); end
    step();
    n_checks++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL en_low_drain got %b exp 00", o_valid); end
    i_valid = 1'b0; i_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    i_cmd = 2'b01; i_data_bus = 32'hAAAA_0001; i_valid = 1'b1; i_ready = 2'b00;
    step();
    i_cmd = 2'b10; i_data_bus = 32'hBBBB_0002;
    step();
    i_valid = 1'b0;
    #1;
    n_checks++; if (o_valid !== 2'b11) begin n_fail++; $display("FAIL rstmid_full got %b exp 11", o_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (o_valid !== 2'b00 || o_data_bus !== '0) begin
      n_fail++; $display("FAIL rstmid_clear got v=%b d=%h exp v=00 d=0", o_valid, o_data_bus);
    end
    step();
    rst = 1'b0; i_ready = 2'b11;
    step();
    n_checks++; if (o_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_stale got %b exp 00", o_valid); end
  endtask

  initial begin
    test_reset();
    test_low();
    test_back_to_back();
    test_stream_high();
    test_bcast();
    test_drop();
    test_en_low();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_distribute_1x2_simple_seq

`default_nettype wire
